// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with input FIFO, run-time prescaler, 1/2 stop bits and per-frame parity.
// Optional line-break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_fifo_cfg #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PS_W       = 16
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [WIDTH-1:0]            P_DATA,
    input  logic                        DATA_VALID,
    output logic                        DATA_READY,
    input  logic                        PAR_EN,
    input  logic                        PAR_TYP,
    input  logic                        STOP2,
    input  logic [PS_W-1:0]             PRESCALE,
`ifdef UART_TX_BREAK_EN
    input  logic                        SEND_BREAK,
`endif
    output logic                        TX_OUT,
    output logic                        Busy,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int IDX_W = $clog2(WIDTH + 5);

    localparam logic [PS_W-1:0]  PS_ONE    = PS_W'(1);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_TX_BREAK_EN
        ,
        BREAK
`endif
    } state_t;

    function automatic logic parity_bit(input logic [WIDTH-1:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

    function automatic logic [PS_W-1:0] eff_prescale(input logic [PS_W-1:0] ps);
        return (ps == '0) ? PS_ONE : ps;
    endfunction

    // FIFO storage and pointers
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;
    logic [WIDTH-1:0] head;

    // Frame sequencer state
    state_t           state_q, state_d;
    logic [PS_W-1:0]  cnt_q, cnt_d;
    logic [PS_W-1:0]  p_q, p_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic             par_en_q, par_en_d;
    logic             stop2_q, stop2_d;
    logic             second_q, second_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             bit_end;
    logic             launch;
`ifdef UART_TX_BREAK_EN
    logic             mark_q, mark_d;
    logic [IDX_W-1:0] brk_last;

    assign brk_last = IDX_W'(WIDTH + 1) + IDX_W'(par_en_q) + IDX_W'(stop2_q);
`endif

    assign DATA_READY = (count_q != FULL_CNT);
    assign FIFO_COUNT = count_q;
    assign head       = mem_q[rd_ptr_q];
    assign push       = DATA_VALID && DATA_READY;
    assign TX_OUT     = tx_q;
    assign Busy       = busy_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= P_DATA;
    end

    // Every state ends a bit when the down-counter reaches zero; launch marks a frame boundary
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        par_en_d = par_en_q;
        stop2_d  = stop2_q;
        second_d = second_q;
`ifdef UART_TX_BREAK_EN
        mark_d   = mark_q;
`endif
        pop      = 1'b0;
        launch   = 1'b0;
        bit_end  = (cnt_q == '0);
        if (!bit_end) cnt_d = cnt_q - PS_ONE;

        case (state_q)
            IDLE: launch = 1'b1;
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                    cnt_d   = p_q - PS_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = p_q - PS_ONE;
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_DATA) begin
                        state_d  = par_en_q ? PARITY : STOP;
                        second_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d  = STOP;
                    second_d = 1'b0;
                    cnt_d    = p_q - PS_ONE;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && !second_q) begin
                        second_d = 1'b1;
                        cnt_d    = p_q - PS_ONE;
                    end else begin
                        launch = 1'b1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            // Low for at least one frame of bit slots, then held while requested, then one mark slot
            BREAK: begin
                if (bit_end) begin
                    cnt_d = p_q - PS_ONE;
                    if (mark_q) begin
                        launch = 1'b1;
                    end else if (idx_q != brk_last) begin
                        idx_d = idx_q + IDX_ONE;
                    end else if (!SEND_BREAK) begin
                        mark_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d = IDLE;
`ifdef UART_TX_BREAK_EN
            if (SEND_BREAK) begin
                state_d  = BREAK;
                mark_d   = 1'b0;
                idx_d    = '0;
                p_d      = eff_prescale(PRESCALE);
                cnt_d    = eff_prescale(PRESCALE) - PS_ONE;
                par_en_d = PAR_EN;
                stop2_d  = STOP2;
            end else
`endif
            if (count_q != '0) begin
                pop      = 1'b1;
                state_d  = START;
                shift_d  = head;
                par_d    = parity_bit(head, PAR_TYP);
                par_en_d = PAR_EN;
                stop2_d  = STOP2;
                p_d      = eff_prescale(PRESCALE);
                cnt_d    = eff_prescale(PRESCALE) - PS_ONE;
            end
        end
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            PARITY:  tx_d = par_q;
`ifdef UART_TX_BREAK_EN
            BREAK:   tx_d = mark_q;
`endif
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_q != IDLE);
    end

    // Line and Busy are registered copies of the current state, one cycle behind it
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            p_q      <= PS_ONE;
            idx_q    <= '0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            second_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_BREAK_EN
            mark_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            idx_q    <= idx_d;
            par_en_q <= par_en_d;
            stop2_q  <= stop2_d;
            second_q <= second_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
`ifdef UART_TX_BREAK_EN
            mark_q   <= mark_d;
`endif
        end
        shift_q <= shift_d;
        par_q   <= par_d;
    end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Directed bench for uart_tx_fifo_cfg: frame shapes, timing, FIFO back-pressure, reset abort
// and, when UART_TX_BREAK_EN is defined, break generation.
module tb_uart_tx_fifo_cfg;

    localparam int WIDTH      = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int PS_W       = 16;

    logic                        CLK = 1'b0;
    logic                        RST;
    logic [WIDTH-1:0]            P_DATA;
    logic                        DATA_VALID;
    logic                        DATA_READY;
    logic                        PAR_EN;
    logic                        PAR_TYP;
    logic                        STOP2;
    logic [PS_W-1:0]             PRESCALE;
`ifdef UART_TX_BREAK_EN
    logic                        SEND_BREAK;
`endif
    logic                        TX_OUT;
    logic                        Busy;
    logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT;

    int checks = 0;
    int errors = 0;

    logic [63:0] wave;
    logic [63:0] exp_wave;
    int          busy_n;
    int          saw_full;
    int          max_cnt;
    int          rdy_bad;
    int          n_acc;
    logic        acc;
    logic [7:0]  words [6] = '{8'h11, 8'h5A, 8'hC3, 8'h80, 8'h01, 8'hFE};

    uart_tx_fifo_cfg #(
        .WIDTH(WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .PS_W(PS_W)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .P_DATA(P_DATA),
        .DATA_VALID(DATA_VALID),
        .DATA_READY(DATA_READY),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .STOP2(STOP2),
        .PRESCALE(PRESCALE),
`ifdef UART_TX_BREAK_EN
        .SEND_BREAK(SEND_BREAK),
`endif
        .TX_OUT(TX_OUT),
        .Busy(Busy),
        .FIFO_COUNT(FIFO_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        P_DATA     = w;
        DATA_VALID = 1'b1;
        step();
        DATA_VALID = 1'b0;
    endtask

    // Records TX_OUT chronologically (bit i = cycle i) and counts Busy cycles
    task automatic grab(input int n, output logic [63:0] w, output int b);
        w = '0;
        b = 0;
        for (int i = 0; i < n; i++) begin
            w[i] = TX_OUT;
            if (Busy) b++;
            step();
        end
    endtask

    function automatic logic [63:0] expand(input logic [31:0] bits, input int nbits, input int p);
        logic [63:0] w = '0;
        int          k = 0;
        for (int i = 0; i < nbits; i++) begin
            for (int j = 0; j < p; j++) begin
                w[k] = bits[i];
                k++;
            end
        end
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

    initial begin
        RST        = 1'b1;
        DATA_VALID = 1'b0;
        P_DATA     = '0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        STOP2      = 1'b0;
        PRESCALE   = 16'd4;
`ifdef UART_TX_BREAK_EN
        SEND_BREAK = 1'b0;
`endif
        step();
        step();
        check("rst_tx", TX_OUT, 1);
        check("rst_busy", Busy, 0);
        check("rst_ready", DATA_READY, 1);
        check("rst_count", FIFO_COUNT, 0);
        RST = 1'b0;
        step();

        // 0xA5, P=4, even parity, one stop bit
        PRESCALE = 16'd4;
        PAR_EN   = 1'b1;
        PAR_TYP  = 1'b0;
        STOP2    = 1'b0;
        push(8'hA5);
        check("a5_count_after_push", FIFO_COUNT, 1);
        step();
        check("a5_tx_before_start", TX_OUT, 1);
        check("a5_busy_before_start", Busy, 0);
        step();
        grab(44, wave, busy_n);
        check("a5_even_wave", wave, expand({1'b1, 1'b0, 8'hA5, 1'b0}, 11, 4));
        check("a5_even_busy", busy_n, 44);
        check("a5_even_tx_after", TX_OUT, 1);
        check("a5_even_busy_after", Busy, 0);
        check("a5_even_count_after", FIFO_COUNT, 0);
        step();

        // Odd parity, two stop bits
        PAR_TYP = 1'b1;
        STOP2   = 1'b1;
        push(8'hA5);
        step();
        step();
        grab(48, wave, busy_n);
        check("a5_odd_wave", wave, expand({2'b11, 1'b1, 8'hA5, 1'b0}, 12, 4));
        check("a5_odd_busy", busy_n, 48);
        check("a5_odd_busy_after", Busy, 0);
        step();

        // PRESCALE=0 behaves as P=1
        PRESCALE = 16'd0;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        STOP2    = 1'b0;
        push(8'h00);
        step();
        step();
        grab(12, wave, busy_n);
        check("ps0_wave", wave, expand({2'b11, 1'b1, 8'h00, 1'b0}, 12, 1));
        check("ps0_busy", busy_n, 10);
        step();

        // Six words back-to-back through a 4-deep FIFO at P=1
        PRESCALE = 16'd1;
        saw_full = 0;
        max_cnt  = 0;
        rdy_bad  = 0;
        n_acc    = 0;
        exp_wave = '0;
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 10; j++) begin
                exp_wave[k*10+j] = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : words[k][j-1];
            end
        end
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    P_DATA     = words[k];
                    DATA_VALID = 1'b1;
                    acc        = 1'b0;
                    for (int c = 0; c < 100 && !acc; c++) begin
                        if (FIFO_COUNT == 3'd4) saw_full++;
                        if (int'(FIFO_COUNT) > max_cnt) max_cnt = int'(FIFO_COUNT);
                        if (DATA_READY != (FIFO_COUNT != 3'd4)) rdy_bad++;
                        acc = DATA_READY;
                        step();
                    end
                    if (acc) n_acc++;
                end
                DATA_VALID = 1'b0;
            end
            begin
                step();
                step();
                step();
                grab(60, wave, busy_n);
            end
        join
        check("b2b_accepted", n_acc, 6);
        check("b2b_full_seen", saw_full > 0, 1);
        check("b2b_max_count", max_cnt, 4);
        check("b2b_ready_vs_full", rdy_bad, 0);
        check("b2b_wave", wave, exp_wave);
        check("b2b_busy_no_gap", busy_n, 60);
        check("b2b_count_after", FIFO_COUNT, 0);
        check("b2b_busy_after", Busy, 0);
        step();

        // Reset during DATA of the second of three queued frames
        PRESCALE   = 16'd2;
        DATA_VALID = 1'b1;
        P_DATA     = 8'h0F;
        step();
        P_DATA     = 8'h33;
        step();
        P_DATA     = 8'hF0;
        step();
        DATA_VALID = 1'b0;
        repeat (27) step();
        check("abort_busy_before", Busy, 1);
        check("abort_count_before", FIFO_COUNT, 1);
        RST = 1'b1;
        step();
        check("abort_tx", TX_OUT, 1);
        check("abort_busy", Busy, 0);
        check("abort_count", FIFO_COUNT, 0);
        check("abort_ready", DATA_READY, 1);
        RST = 1'b0;
        grab(40, wave, busy_n);
        check("abort_line_quiet", wave, 64'h0000_00FF_FFFF_FFFF);
        check("abort_no_busy", busy_n, 0);

`ifdef UART_TX_BREAK_EN
        // SEND_BREAK for 5 cycles at P=2 still gives a full 20-cycle break, then a 2-cycle mark
        PRESCALE = 16'd2;
        PAR_EN   = 1'b0;
        STOP2    = 1'b0;
        fork
            begin
                SEND_BREAK = 1'b1;
                repeat (5) step();
                SEND_BREAK = 1'b0;
            end
            begin
                step();
                step();
                grab(24, wave, busy_n);
            end
        join
        check("brk_wave", wave, 64'h0000_0000_00F0_0000);
        check("brk_busy", busy_n, 22);
        check("brk_idle_after", Busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
